// File: rtl/microondas_controle.sv
// Microwave sequencing controller: assembles the M:SS cook time from keypad
// digits and runs the cook / pause / done sequence with registered outputs.
//
// state     | meaning
// S_IDLE    | keypad enabled, digits loadable, magnetron off
// S_COOKING | magnetron on, time counts down one BCD second per tick
// S_PAUSED  | magnetron off, time frozen, waiting for start or stop
// S_DONE    | cook finished, done held for DONE_SECONDS ticks
module microondas_controle #(
  parameter int DONE_SECONDS = 3
) (
  input  logic       Hz_100_clock,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic       magnetron_on,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_COOKING, S_PAUSED, S_DONE} state_t;

  state_t     state;
  logic       loadn_q, pgt_q, startn_q, stopn_q;
  logic [3:0] dwell_cnt;

  logic       key_press, tick, start_edge, stop_edge;
  logic       time_zero, last_sec;
  logic [3:0] dec_units, dec_tens, dec_min;

  assign key_press  = loadn_q & ~loadn;
  assign tick       = ~pgt_q & pgt_1Hz;
  assign start_edge = startn_q & ~startn;
  assign stop_edge  = stopn_q & ~stopn;

  assign time_zero = (min_units == 4'd0) && (sec_tens == 4'd0) && (sec_units == 4'd0);
  assign last_sec  = (min_units == 4'd0) && (sec_tens == 4'd0) && (sec_units == 4'd1);

  // BCD down-count; a tens digit above 5 simply decrements like any other
  always_comb begin
    dec_units = sec_units - 4'd1;
    dec_tens  = sec_tens;
    dec_min   = min_units;
    if (sec_units == 4'd0) begin
      dec_units = 4'd9;
      dec_tens  = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_units - 4'd1;
      end
    end
  end

  always_ff @(posedge Hz_100_clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      loadn_q      <= 1'b1;
      pgt_q        <= 1'b0;
      startn_q     <= 1'b1;
      stopn_q      <= 1'b1;
      dwell_cnt    <= 4'd0;
      sec_units    <= 4'd0;
      sec_tens     <= 4'd0;
      min_units    <= 4'd0;
      enablen      <= 1'b0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      loadn_q  <= loadn;
      pgt_q    <= pgt_1Hz;
      startn_q <= startn;
      stopn_q  <= stopn;

      case (state)
        S_IDLE: begin
          if (key_press && (D <= 4'd9)) begin
            min_units <= sec_tens;
            sec_tens  <= sec_units;
            sec_units <= D;
          end
          // start decision uses the time as it was before any same-cycle shift
          if (stop_edge) begin
            min_units <= 4'd0;
            sec_tens  <= 4'd0;
            sec_units <= 4'd0;
          end else if (start_edge && door_closed && !time_zero) begin
            state        <= S_COOKING;
            enablen      <= 1'b1;
            magnetron_on <= 1'b1;
          end
        end

        S_COOKING: begin
          if (stop_edge || !door_closed) begin
            state        <= S_PAUSED;
            magnetron_on <= 1'b0;
          end else if (tick) begin
            min_units <= dec_min;
            sec_tens  <= dec_tens;
            sec_units <= dec_units;
            if (last_sec) begin
              state        <= S_DONE;
              magnetron_on <= 1'b0;
              done         <= 1'b1;
              dwell_cnt    <= 4'(DONE_SECONDS);
            end
          end
        end

        S_PAUSED: begin
          if (stop_edge) begin
            state     <= S_IDLE;
            enablen   <= 1'b0;
            min_units <= 4'd0;
            sec_tens  <= 4'd0;
            sec_units <= 4'd0;
          end else if (start_edge && door_closed) begin
            state        <= S_COOKING;
            magnetron_on <= 1'b1;
          end
        end

        S_DONE: begin
          if (stop_edge || (tick && (dwell_cnt == 4'd1))) begin
            state     <= S_IDLE;
            enablen   <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= 4'd0;
          end else if (tick) begin
            dwell_cnt <= dwell_cnt - 4'd1;
          end
        end

        default: begin
          state        <= S_IDLE;
          enablen      <= 1'b0;
          magnetron_on <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microondas_controle.sv
// Bench for microondas_controle: directed and random key/start/stop/tick/door
// events against a decimal-arithmetic model, checked by a change-driven monitor.
module tb_microondas_controle;

  localparam int DS = 3;

  localparam int OP_KEY        = 0;
  localparam int OP_START      = 1;
  localparam int OP_STOP       = 2;
  localparam int OP_TICK       = 3;
  localparam int OP_DOOR       = 4;
  localparam int OP_STOP_START = 5;
  localparam int OP_TICK_STOP  = 6;
  localparam int OP_KEY_START  = 7;

  localparam int M_IDLE  = 0;
  localparam int M_COOK  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       resetn;
  logic [3:0] D;
  logic       loadn, pgt_1Hz, startn, stopn, door_closed;
  logic       enablen, magnetron_on, done;
  logic [3:0] sec_units, sec_tens, min_units;
  logic [14:0] snap;

  int checks = 0;
  int errors = 0;

  microondas_controle #(.DONE_SECONDS(DS)) dut (
    .Hz_100_clock(clk),
    .resetn(resetn),
    .D(D),
    .loadn(loadn),
    .pgt_1Hz(pgt_1Hz),
    .startn(startn),
    .stopn(stopn),
    .door_closed(door_closed),
    .enablen(enablen),
    .sec_units(sec_units),
    .sec_tens(sec_tens),
    .min_units(min_units),
    .magnetron_on(magnetron_on),
    .done(done)
  );

  assign snap = {enablen, magnetron_on, done, min_units, sec_tens, sec_units};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: time held as the decimal number M*100 + T*10 + U
  int mode = M_IDLE;
  int n = 0;
  int dwell = 0;
  bit door = 1'b1;
  logic [14:0] last_exp = '0;
  logic [14:0] exp_q[$];

  function automatic logic [14:0] mk(input bit en, input bit mag, input bit dn,
                                     input int m, input int t, input int u);
    return {en, mag, dn, 4'(m), 4'(t), 4'(u)};
  endfunction

  function automatic logic [14:0] model_snap();
    return mk(mode != M_IDLE, mode == M_COOK, mode == M_DONE, n / 100, (n / 10) % 10, n % 10);
  endfunction

  task automatic model_stop();
    case (mode)
      M_IDLE:  n = 0;
      M_COOK:  mode = M_PAUSE;
      M_PAUSE: begin mode = M_IDLE; n = 0; end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic model_start();
    if (mode == M_IDLE && door && n != 0) mode = M_COOK;
    else if (mode == M_PAUSE && door) mode = M_COOK;
  endtask

  task automatic model_op(input int op, input int d);
    bit go;
    case (op)
      OP_KEY: if (mode == M_IDLE && d <= 9) n = (n % 100) * 10 + d;
      OP_START: model_start();
      OP_STOP, OP_STOP_START, OP_TICK_STOP: model_stop();
      OP_TICK: begin
        if (mode == M_COOK) begin
          n = (n % 100 == 0) ? n - 41 : n - 1;
          if (n == 0) begin mode = M_DONE; dwell = DS; end
        end else if (mode == M_DONE) begin
          dwell--;
          if (dwell == 0) mode = M_IDLE;
        end
      end
      OP_DOOR: begin
        door = (d != 0);
        if (!door && mode == M_COOK) mode = M_PAUSE;
      end
      OP_KEY_START: begin
        if (mode == M_IDLE) begin
          go = door && (n != 0);
          if (d <= 9) n = (n % 100) * 10 + d;
          if (go) mode = M_COOK;
        end else begin
          model_start();
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_exp();
    logic [14:0] e;
    e = model_snap();
    if (e != last_exp) begin
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  // monitor: every change of the output vector must match the next prediction
  bit mon_en = 1'b0;
  bit mon_started = 1'b0;
  logic [14:0] last_seen;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!mon_started) begin
        last_seen = snap;
        mon_started = 1'b1;
      end else if (snap !== last_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h expected %h (no change predicted)", snap, last_seen);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          if (snap !== e) begin
            errors++;
            $display("FAIL scoreboard: got %h expected %h", snap, e);
          end
        end
        last_seen = snap;
      end
    end
  end

  task automatic chk(input string name, input logic [14:0] e);
    checks++;
    if (snap !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, snap, e);
    end
  endtask

  task automatic do_op(input int op, input int d);
    @(negedge clk); #1;
    case (op)
      OP_KEY:        begin D = 4'(d); loadn = 1'b0; end
      OP_START:      startn = 1'b0;
      OP_STOP:       stopn = 1'b0;
      OP_TICK:       pgt_1Hz = 1'b1;
      OP_DOOR:       door_closed = (d != 0);
      OP_STOP_START: begin stopn = 1'b0; startn = 1'b0; end
      OP_TICK_STOP:  begin pgt_1Hz = 1'b1; stopn = 1'b0; end
      OP_KEY_START:  begin D = 4'(d); loadn = 1'b0; startn = 1'b0; end
      default: ;
    endcase
    model_op(op, d);
    push_exp();
    @(negedge clk); #1;
    loadn = 1'b1; startn = 1'b1; stopn = 1'b1; pgt_1Hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic keys3(input int a, input int b, input int c);
    do_op(OP_KEY, a);
    do_op(OP_KEY, b);
    do_op(OP_KEY, c);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) do_op(OP_TICK, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b1; D = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", mk(0, 0, 0, 0, 0, 0));
    #1 resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    keys3(1, 3, 0);                 chk("keys_130", mk(0, 0, 0, 1, 3, 0));
    do_op(OP_KEY, 9);
    do_op(OP_STOP, 0);              chk("stop_clears", mk(0, 0, 0, 0, 0, 0));
    do_op(OP_KEY, 12);              chk("key_invalid", mk(0, 0, 0, 0, 0, 0));

    keys3(0, 0, 5);
    do_op(OP_DOOR, 1);
    do_op(OP_START, 0);             chk("start_cook", mk(1, 1, 0, 0, 0, 5));
    ticks(4);                       chk("cook_0_01", mk(1, 1, 0, 0, 0, 1));
    ticks(1);                       chk("done_entry", mk(1, 0, 1, 0, 0, 0));
    ticks(DS - 1);                  chk("done_dwell", mk(1, 0, 1, 0, 0, 0));
    ticks(1);                       chk("done_exit", mk(0, 0, 0, 0, 0, 0));

    keys3(1, 0, 0);
    do_op(OP_START, 0);
    ticks(1);                       chk("borrow_min", mk(1, 1, 0, 0, 5, 9));
    do_op(OP_STOP, 0);              chk("stop_pause", mk(1, 0, 0, 0, 5, 9));
    do_op(OP_STOP, 0);

    keys3(0, 7, 0);
    do_op(OP_START, 0);
    ticks(1);                       chk("tens_gt5", mk(1, 1, 0, 0, 6, 9));
    do_op(OP_STOP, 0);
    do_op(OP_STOP, 0);

    keys3(9, 5, 9);                 chk("keys_959", mk(0, 0, 0, 9, 5, 9));
    do_op(OP_START, 0);
    ticks(100);                     chk("ticks_100", mk(1, 1, 0, 8, 1, 9));
    do_op(OP_STOP, 0);
    do_op(OP_STOP, 0);

    keys3(0, 3, 0);
    do_op(OP_START, 0);
    ticks(2);
    do_op(OP_DOOR, 0);              chk("door_pause", mk(1, 0, 0, 0, 2, 8));
    ticks(2);                       chk("paused_hold", mk(1, 0, 0, 0, 2, 8));
    do_op(OP_DOOR, 1);
    do_op(OP_START, 0);             chk("resume", mk(1, 1, 0, 0, 2, 8));
    do_op(OP_STOP, 0);
    do_op(OP_STOP, 0);              chk("stop_twice", mk(0, 0, 0, 0, 0, 0));

    do_op(OP_DOOR, 0);
    keys3(0, 0, 5);
    do_op(OP_START, 0);             chk("start_door_open", mk(0, 0, 0, 0, 0, 5));
    do_op(OP_DOOR, 1);
    do_op(OP_STOP, 0);
    do_op(OP_START, 0);             chk("start_zero", mk(0, 0, 0, 0, 0, 0));

    do_op(OP_KEY, 5);
    do_op(OP_START, 0);
    do_op(OP_STOP_START, 0);        chk("stop_over_start", mk(1, 0, 0, 0, 0, 5));
    do_op(OP_STOP, 0);
    do_op(OP_KEY, 5);
    do_op(OP_START, 0);
    do_op(OP_TICK_STOP, 0);         chk("stop_over_tick", mk(1, 0, 0, 0, 0, 5));
    do_op(OP_STOP, 0);

    do_op(OP_KEY_START, 4);         chk("key_start_pre0", mk(0, 0, 0, 0, 0, 4));
    do_op(OP_KEY_START, 2);         chk("key_start_go", mk(1, 1, 0, 0, 4, 2));
    do_op(OP_STOP, 0);
    do_op(OP_STOP, 0);

    keys3(0, 1, 3);
    do_op(OP_START, 0);
    ticks(1);                       chk("cook_0_12", mk(1, 1, 0, 0, 1, 2));
    @(negedge clk); #3;
    mode = M_IDLE; n = 0; dwell = 0;
    push_exp();
    resetn = 1'b0;
    #1;                             chk("async_reset", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk); #1;
    resetn = 1'b1;
    repeat (4) @(negedge clk);      chk("post_reset", mk(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30)      do_op(OP_KEY, int'($urandom_range(0, 15)));
      else if (r < 40) do_op(OP_START, 0);
      else if (r < 47) do_op(OP_STOP, 0);
      else if (r < 80) do_op(OP_TICK, 0);
      else if (r < 88) do_op(OP_DOOR, (r % 3 == 0) ? 0 : 1);
      else if (r < 92) do_op(OP_STOP_START, 0);
      else if (r < 96) do_op(OP_TICK_STOP, 0);
      else             do_op(OP_KEY_START, int'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    chk("final_state", model_snap());
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
